text_cursor_ctrl: RTL
=====================

// Module: text_cursor_ctrl
// PURPOSE
//   Sequences writes into the 4096x8 text character RAM that the VGA text path reads at {row[4:0], col[6:0]}.
//   Accepts raw PS/2 scancode bytes, filters break/extended prefixes and translates make codes through the external scancode->ASCII ROM.
//   Owns the cursor. Handles printable keys, Enter and Backspace, line wrap, row clearing and full-screen clear.
//   Sits between the PS/2 receiver and the character RAM write port.
// PARAMETERS
//   COLS      70     visible columns per row; col range 0..COLS-1, COLS<=128
//   ROWS      30     visible rows; row range 0..ROWS-1, ROWS<=32
//   BRK_CODE  8'hF0  break prefix; the next byte is discarded
//   EXT_CODE  8'hE0  extended prefix; the next byte is discarded
// PORTS
//   clk         in   1   single clock, all state on posedge
//   rst         in   1   synchronous, active-high reset
//   kb_valid    in   1   scancode byte valid
//   kb_code     in   8   scancode byte
//   kb_ready    out  1   byte accepted on the cycle where kb_valid&&kb_ready
//   clear_req   in   1   one-cycle pulse: blank the whole screen and home the cursor
//   lut_addr    out  8   scancode->ASCII ROM address; ROM data is valid 1 cycle later
//   lut_data    in   8   ASCII code; 8'h00 = unmapped
//   wr_en       out  1   character RAM write strobe
//   wr_addr     out  12  {row[4:0], col[6:0]}
//   wr_data     out  8   ASCII character
//   cursor_row  out  5   current row
//   cursor_col  out  7   current column
//   busy        out  1   FSM is not in IDLE
// BEHAVIOUR
//   Reset: state IDLE; cursor (0,0); brk/ext flags 0; clear_pend 0; wr_en 0; wr_addr/wr_data/lut_addr 0.
//     kb_ready is 1 on the first cycle after reset. RAM contents are not touched.
//   kb_ready = (state==IDLE) && !clear_pend.
//   FSM states: IDLE, LOOKUP, WRITE, ROWCLR, SCRCLR.
//   IDLE, accepted byte:
//     byte==BRK_CODE: set brk, stay in IDLE.
//     byte==EXT_CODE: set ext, stay in IDLE.
//     brk|ext set: discard the byte and clear both flags.
//     8'h5A (Enter): col<=0 and row advance.
//     8'h66 (Backspace): if col>0, col-1; else if row>0, row-1 and col=COLS-1; then write 8'h20 at the new position.
//       At (0,0) Backspace is a no-op.
//     any other byte: lut_addr<=byte, go to LOOKUP.
//   LOOKUP (1 cycle): go to WRITE.
//   WRITE: if lut_data!=0, assert wr_en for one cycle at the cursor, then advance col.
//     If col==COLS-1, col<=0 and row advance.
//     If lut_data==0, no write, back to IDLE.
//   Row advance: row<=(row==ROWS-1)?0:row+1, then ROWCLR.
//     ROWCLR writes 8'h20 to cols 0..COLS-1 of the new row, one per cycle (COLS cycles), then IDLE.
//   Typematic repeats of a held make code are accepted as new keys.
//   clear_req: latched into clear_pend in any state.
//     Serviced when the FSM next enters IDLE, taking priority over kb_valid.
//     SCRCLR writes 8'h20 over rows 0..ROWS-1 x cols 0..COLS-1, row-major, one cell per cycle.
//     Then cursor (0,0) and clear_pend<=0.
//     A clear_req arriving during SCRCLR sets clear_pend again, so one further full clear follows.
//   Latency: printable key accept -> wr_en = 2 cycles.
//     Backspace/ROWCLR/SCRCLR first write = 1 cycle after entry.
//   wr_en is never asserted outside WRITE, ROWCLR, SCRCLR or the Backspace write cycle.
//     wr_addr column is always < COLS.
//   rst mid-ROWCLR/SCRCLR: abort immediately; cells already written stay written.
//   cursor_row/cursor_col update in the same cycle as the write that moves them.
// STRUCTURE
//   text_ctrl_pkg:
//     state enum
//     SC_ENTER=8'h5A, SC_BKSP=8'h66, ASCII_SPACE=8'h20
//     address-pack function {row,col}->12 bits
//   Sub-module ps2_prefix_filter: BRK/EXT flag tracking; outputs a make-code valid pulse.
//   Cursor, FSM and clear counters stay in text_cursor_ctrl.
// TESTING
//   1. After rst, send 8'h1C with lut=8'h61 -> 2 cycles later wr_en, wr_addr=12'h000, wr_data=8'h61; cursor_col=1.
//   2. Send F0,1C -> no wr_en, cursor unchanged; kb_ready stays 1 throughout.
//   3. 70 printable keys from (0,0) -> 70th write at col 69; cursor becomes (1,0); 70 space writes to 12'h080..12'h0C5; busy during ROWCLR.
//   4. Cursor (1,0), Backspace -> wr_addr={5'd0,7'd69}, wr_data=8'h20, cursor (0,69). Backspace at (0,0) -> no write.
//   5. Enter at row 29 -> cursor (0,0); row 0 cleared with 70 writes at 12'h000..12'h045.
//   6. clear_req during ROWCLR -> ROWCLR completes; SCRCLR issues 2100 writes; cursor (0,0); kb_ready low until done.
//      rst asserted mid-SCRCLR -> wr_en 0 and idle next cycle.

Source files
------------

// File: rtl/text_ctrl_pkg.sv
// Shared types and constants for the text-mode cursor controller.
// Character RAM address is {row[4:0], col[6:0]}.
package text_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITE,
        ST_ROWCLR,
        ST_SCRCLR
    } state_t;

    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_BKSP     = 8'h66;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    function automatic logic [11:0] pack_addr(input logic [4:0] row, input logic [6:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/ps2_prefix_filter.sv
// Tracks PS/2 break/extended prefixes and flags the accepted bytes that are genuine make codes.
// The byte following any prefix is swallowed so key releases never reach the FSM.
module ps2_prefix_filter #(
    parameter logic [7:0] BRK_CODE = 8'hF0,
    parameter logic [7:0] EXT_CODE = 8'hE0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic [7:0] code,
    output logic       make_valid,
    output logic [7:0] make_code
);

    logic brk_flag;
    logic ext_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
        end else if (accept) begin
            if (code == BRK_CODE) begin
                brk_flag <= 1'b1;
            end else if (code == EXT_CODE) begin
                ext_flag <= 1'b1;
            end else if (brk_flag || ext_flag) begin
                brk_flag <= 1'b0;
                ext_flag <= 1'b0;
            end
        end
    end

    assign make_valid = accept && (code != BRK_CODE) && (code != EXT_CODE) && !(brk_flag || ext_flag);
    assign make_code  = code;

endmodule

// File: rtl/text_cursor_ctrl.sv
// Cursor owner and write sequencer for the text character RAM: printable keys, Enter,
// Backspace, line wrap with row clear, and full-screen clear on request.
module text_cursor_ctrl
    import text_ctrl_pkg::*;
#(
    parameter int         COLS     = 70,
    parameter int         ROWS     = 30,
    parameter logic [7:0] BRK_CODE = 8'hF0,
    parameter logic [7:0] EXT_CODE = 8'hE0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kb_valid,
    input  logic [7:0]  kb_code,
    output logic        kb_ready,
    input  logic        clear_req,
    output logic [7:0]  lut_addr,
    input  logic [7:0]  lut_data,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t     state;
    logic       clear_pend;
    logic [4:0] clr_row;
    logic [6:0] clr_col;
    logic [4:0] next_row;
    logic       make_valid;
    logic [7:0] make_code;

    assign kb_ready = (state == ST_IDLE) && !clear_pend;
    assign busy     = (state != ST_IDLE);
    assign next_row = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;

    ps2_prefix_filter #(
        .BRK_CODE (BRK_CODE),
        .EXT_CODE (EXT_CODE)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .accept     (kb_valid && kb_ready),
        .code       (kb_code),
        .make_valid (make_valid),
        .make_code  (make_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            clear_pend <= 1'b0;
            clr_row    <= 5'd0;
            clr_col    <= 7'd0;
            cursor_row <= 5'd0;
            cursor_col <= 7'd0;
            wr_en      <= 1'b0;
            wr_addr    <= 12'd0;
            wr_data    <= 8'd0;
            lut_addr   <= 8'd0;
        end else begin
            wr_en <= 1'b0;
            if (clear_req) begin
                clear_pend <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (clear_pend) begin
                        // Pending flag is consumed on entry so a request arriving
                        // during the sweep re-arms it for exactly one more clear.
                        clear_pend <= clear_req;
                        clr_row    <= 5'd0;
                        clr_col    <= 7'd0;
                        state      <= ST_SCRCLR;
                    end else if (make_valid) begin
                        if (make_code == SC_ENTER) begin
                            cursor_col <= 7'd0;
                            cursor_row <= next_row;
                            clr_col    <= 7'd0;
                            state      <= ST_ROWCLR;
                        end else if (make_code == SC_BKSP) begin
                            if (cursor_col != 7'd0) begin
                                cursor_col <= cursor_col - 7'd1;
                                wr_en      <= 1'b1;
                                wr_addr    <= pack_addr(cursor_row, cursor_col - 7'd1);
                                wr_data    <= ASCII_SPACE;
                            end else if (cursor_row != 5'd0) begin
                                cursor_row <= cursor_row - 5'd1;
                                cursor_col <= LAST_COL;
                                wr_en      <= 1'b1;
                                wr_addr    <= pack_addr(cursor_row - 5'd1, LAST_COL);
                                wr_data    <= ASCII_SPACE;
                            end
                        end else begin
                            lut_addr <= make_code;
                            state    <= ST_LOOKUP;
                        end
                    end
                end
                ST_LOOKUP: begin
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                    if (lut_data != 8'd0) begin
                        wr_en   <= 1'b1;
                        wr_addr <= pack_addr(cursor_row, cursor_col);
                        wr_data <= lut_data;
                        if (cursor_col == LAST_COL) begin
                            cursor_col <= 7'd0;
                            cursor_row <= next_row;
                            clr_col    <= 7'd0;
                            state      <= ST_ROWCLR;
                        end else begin
                            cursor_col <= cursor_col + 7'd1;
                        end
                    end
                end
                ST_ROWCLR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= pack_addr(cursor_row, clr_col);
                    wr_data <= ASCII_SPACE;
                    if (clr_col == LAST_COL) begin
                        state <= ST_IDLE;
                    end else begin
                        clr_col <= clr_col + 7'd1;
                    end
                end
                ST_SCRCLR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= pack_addr(clr_row, clr_col);
                    wr_data <= ASCII_SPACE;
                    if (clr_col == LAST_COL) begin
                        clr_col <= 7'd0;
                        if (clr_row == LAST_ROW) begin
                            cursor_row <= 5'd0;
                            cursor_col <= 7'd0;
                            state      <= ST_IDLE;
                        end else begin
                            clr_row <= clr_row + 5'd1;
                        end
                    end else begin
                        clr_col <= clr_col + 7'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
